digit_entry_ctrl: RTL
=====================

Name: digit_entry_ctrl

Overview:
Parametrised player digit-entry controller for the number-guessing game.
- Holds NUM_DIGITS editable digits of base RADIX, each stepped by a rising-edge-detected pushbutton; only the low max_digits digits are active (difficulty).
- On confirm, the entered value is snapshotted and offered to the comparator over a valid/ready handshake; editing is frozen until the comparator accepts.
- Counts accepted guesses for the score/attempt display.

Parameters:
NUM_DIGITS, 3, number of digit positions (1..8)
DIGIT_W, 4, bits per digit; RADIX must be <= 2**DIGIT_W
RADIX, 10, digit base; values run 0..RADIX-1
CNT_W, 8, width of the guess attempt counter
MD_W, 2, width of max_digits; 2**MD_W must be > NUM_DIGITS

Ports:
clk  in  1  system clock, all state on rising edge
restart  in  1  asynchronous active-low reset
max_digits  in  MD_W  number of active digits, from the difficulty select
inc_btn  in  NUM_DIGITS  per-digit increment buttons, level, synchronous/debounced upstream
confirm  in  1  lock-in button, level
clear  in  1  synchronous clear of the entered digits
guess_ready  in  1  comparator accepts the guess
display_digits  out  NUM_DIGITS*DIGIT_W  live entry value; digit i at [i*DIGIT_W +: DIGIT_W]
guess_digits  out  NUM_DIGITS*DIGIT_W  snapshotted guess, same packing
guess_valid  out  1  guess offered to comparator
guess_count  out  CNT_W  accepted guesses, saturating
busy  out  1  high while a guess is pending (entry frozen)

Behaviour:
- Reset (restart=0, asynchronous): display_digits=0, guess_digits=0, guess_valid=0, guess_count=0, busy=0, state=ENTRY. Button history registers reset to all ones, so a button held through reset release does not fire.
- Edge detect: an event occurs when the button is 1 now and was 0 in the previous cycle. One event per press regardless of hold length. The digit updates on the clock edge following the sampled event (1-cycle latency).
- Active digits: effective count eff = min(max_digits, NUM_DIGITS). Digit i is active iff i < eff.
  - Inactive digits are held at 0 every cycle, including when max_digits decreases.
  - Events on inactive digits are ignored.
- Increment: d = (d == RADIX-1) ? 0 : d+1. All buttons act independently in the same cycle.
- clear=1 in ENTRY: all digits go to 0 next cycle. Clear has priority over increments in that cycle. In PENDING, clear is ignored.
- FSM ENTRY:
  - A confirm event with eff > 0 moves the FSM to PENDING.
  - guess_digits captures display_digits as it stood before any same-cycle increment; that increment still applies to display_digits.
  - guess_valid=1 and busy=1 from the next cycle.
  - A confirm event with eff = 0 is ignored.
- FSM PENDING:
  - guess_valid and guess_digits are held stable and entry events are ignored.
  - When guess_valid & guess_ready are sampled high, the FSM returns to ENTRY next cycle with guess_valid=0 and busy=0, and guess_count increments, saturating at 2**CNT_W-1.
  - Confirm events in PENDING are ignored.
  - guess_digits keeps its last value after acceptance.
- guess_ready while in ENTRY has no effect.
- Reset asserted mid-PENDING: immediate return to reset values; no count increment.

Optional Feature:
DIGIT_DEC_EN
- Defined: adds input dec_btn [NUM_DIGITS], edge-detected like inc_btn with history reset to all ones.
  - Decrement rule: d = (d == 0) ? RADIX-1 : d-1.
  - Simultaneous inc and dec events on the same digit cancel, leaving the digit unchanged.
  - Active-digit, clear and PENDING rules apply identically.
- Undefined: no dec_btn port; digits are increment-only.

Test Plan:
- Defaults, max_digits=3, pulse inc_btn[0] ten times (1 cycle high, 1 low) -> digit0 steps 1..9 then 0. Hold inc_btn[1] high 20 cycles -> digit1=1 only.
- max_digits=2, display 5,7,0, press inc_btn[2] -> digit2 stays 0. Then set max_digits=1 -> digit1 becomes 0 next cycle, digit0 stays 5.
- Digits 3,4,2 with guess_ready=0, confirm event -> next cycle guess_valid=1, busy=1, guess_digits=3,4,2. inc_btn[0] and clear are ignored. guess_ready=1 for 1 cycle -> guess_valid=0, guess_count=1.
- Confirm and inc_btn[0] events in the same cycle with digit0=9 -> guess digit0=9, display digit0=0.
- CNT_W=2, complete 5 handshakes -> guess_count=3 (saturated). Assert restart mid-PENDING -> all outputs 0 immediately, asynchronously.
- With DIGIT_DEC_EN defined: dec event on digit0=0 -> 9. Simultaneous inc and dec events on digit0=4 -> 4.

Source files
------------

// File: rtl/digit_entry_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// digit_entry_ctrl
//
// Player digit-entry controller for the number-guessing game. Holds
// NUM_DIGITS editable base-RADIX digits, each stepped by an edge-detected
// pushbutton. Only the low max_digits positions are active; the rest are
// forced to zero. A confirm press snapshots the entry and offers it to the
// comparator over a valid/ready handshake. Editing is frozen until the
// comparator accepts. Accepted guesses are counted with saturation.
//
// Optional feature macro: DIGIT_DEC_EN
//   When defined, a dec_btn input is added. Each digit can then also be
//   decremented, and an increment and a decrement in the same cycle cancel.
//
// Ports:
//   clk            system clock, all state on rising edge
//   restart        asynchronous active-low reset
//   max_digits     number of active digits (difficulty)
//   inc_btn        per-digit increment buttons (level, debounced upstream)
//   dec_btn        per-digit decrement buttons (DIGIT_DEC_EN only)
//   confirm        lock-in button (level)
//   clear          synchronous clear of the entered digits (ignored while busy)
//   guess_ready    comparator accepts the offered guess
//   display_digits live entry value, digit i at [i*DIGIT_W +: DIGIT_W]
//   guess_digits   snapshotted guess, same packing
//   guess_valid    guess offered to comparator
//   guess_count    accepted guesses, saturating
//   busy           high while a guess is pending
// -----------------------------------------------------------------------------
module digit_entry_ctrl #(
    parameter int NUM_DIGITS = 3,
    parameter int DIGIT_W    = 4,
    parameter int RADIX      = 10,
    parameter int CNT_W      = 8,
    parameter int MD_W       = 2
) (
    input  logic                          clk,
    input  logic                          restart,
    input  logic [MD_W-1:0]               max_digits,
    input  logic [NUM_DIGITS-1:0]         inc_btn,
`ifdef DIGIT_DEC_EN
    input  logic [NUM_DIGITS-1:0]         dec_btn,
`endif
    input  logic                          confirm,
    input  logic                          clear,
    input  logic                          guess_ready,
    output logic [NUM_DIGITS*DIGIT_W-1:0] display_digits,
    output logic [NUM_DIGITS*DIGIT_W-1:0] guess_digits,
    output logic                          guess_valid,
    output logic [CNT_W-1:0]              guess_count,
    output logic                          busy
);

    typedef enum logic {
        ENTRY   = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                        state_reg;
    state_t                        state_next;
    logic [NUM_DIGITS-1:0]         inc_hist_reg;
    logic [NUM_DIGITS-1:0]         inc_ev;
    logic [NUM_DIGITS-1:0]         dec_ev;
    logic                          confirm_hist_reg;
    logic                          confirm_ev;
    logic [NUM_DIGITS-1:0]         active;
    logic                          capture;
    logic                          accept;
    logic [NUM_DIGITS*DIGIT_W-1:0] guess_reg;
    logic [CNT_W-1:0]              count_reg;

    // Histories reset to ones so a button held through reset release is
    // seen as already pressed and does not fire.
    assign inc_ev     = inc_btn & ~inc_hist_reg;
    assign confirm_ev = confirm & ~confirm_hist_reg;

`ifdef DIGIT_DEC_EN
    logic [NUM_DIGITS-1:0] dec_hist_reg;

    assign dec_ev = dec_btn & ~dec_hist_reg;

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            dec_hist_reg <= '1;
        end else begin
            dec_hist_reg <= dec_btn;
        end
    end
`else
    assign dec_ev = '0;
`endif

    // 2**MD_W > NUM_DIGITS, so every position index fits in MD_W bits and
    // "i < max_digits" is the same as "i < min(max_digits, NUM_DIGITS)".
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_active
        assign active[gi] = (MD_W'(gi) < max_digits);
    end

    // Per-digit editable register.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [DIGIT_W-1:0] digit_reg;
        logic [DIGIT_W-1:0] digit_next;

        always_comb begin
            digit_next = digit_reg;
            if (!active[gi]) begin
                digit_next = '0;
            end else if (state_reg == ENTRY) begin
                if (clear) begin
                    digit_next = '0;
                end else if (inc_ev[gi] && !dec_ev[gi]) begin
                    digit_next = (digit_reg == DIGIT_W'(RADIX - 1)) ? '0
                                 : digit_reg + DIGIT_W'(1);
                end else if (dec_ev[gi] && !inc_ev[gi]) begin
                    digit_next = (digit_reg == '0) ? DIGIT_W'(RADIX - 1)
                                 : digit_reg - DIGIT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge restart) begin
            if (!restart) begin
                digit_reg <= '0;
            end else begin
                digit_reg <= digit_next;
            end
        end

        assign display_digits[gi*DIGIT_W +: DIGIT_W] = digit_reg;
    end

    // Handshake FSM. capture snapshots the pre-update entry value, so a
    // same-cycle increment lands in the display but not in the guess.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ENTRY: begin
                if (confirm_ev && (max_digits != '0)) begin
                    state_next = PENDING;
                    capture    = 1'b1;
                end
            end
            PENDING: begin
                if (guess_ready) begin
                    state_next = ENTRY;
                    accept     = 1'b1;
                end
            end
            default: state_next = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state_reg        <= ENTRY;
            inc_hist_reg     <= '1;
            confirm_hist_reg <= 1'b1;
            guess_reg        <= '0;
            count_reg        <= '0;
        end else begin
            state_reg        <= state_next;
            inc_hist_reg     <= inc_btn;
            confirm_hist_reg <= confirm;
            if (capture) begin
                guess_reg <= display_digits;
            end
            if (accept && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign guess_digits = guess_reg;
    assign guess_valid  = (state_reg == PENDING);
    assign busy         = (state_reg == PENDING);
    assign guess_count  = count_reg;

endmodule
